// File: rtl/axi_stream_master_if.sv
// rtl/axi_stream_master_if.sv - handshake/data bundle for the axi_stream_master output stage
//
// Purpose : groups the upstream beat input and the downstream valid/ready
//           stream into one interface.
// Signals : valid_input - upstream beat present on data_in this cycle
//           data_in     - upstream beat (DATA_WIDTH)
//           ready_sys   - downstream consumer accepts data_out
//           valid       - data_out holds a valid beat (TVALID)
//           data_out    - head-of-FIFO beat (TDATA)
// Modports: master - the output stage itself (drives valid/data_out)
//           slave  - the surrounding producer/consumer (drives the rest)

interface axi_stream_master_if #(
  parameter int DATA_WIDTH = 512
);
  logic                  valid_input;
  logic                  ready_sys;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    input  valid_input,
    input  ready_sys,
    input  data_in,
    output valid,
    output data_out
  );

  modport slave (
    output valid_input,
    output ready_sys,
    output data_in,
    input  valid,
    input  data_out
  );
endinterface

// File: rtl/axi_stream_master.sv
// rtl/axi_stream_master.sv - FWFT FIFO output stage presenting beats on a valid/ready stream
//
// Purpose : buffers beats from a producer that cannot be stalled and presents
//           them to the consumer with AXI-Stream valid/ready semantics.
//           Beats arriving while the FIFO is full (and no read happens in the
//           same cycle) are dropped.
// Ports   : clk    - rising-edge clock
//           resetN - asynchronous active-low reset; clears pointers, count
//                    and storage
//           bus    - axi_stream_master_if.master (valid_input, data_in,
//                    ready_sys in; valid, data_out out)

module axi_stream_master #(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  axi_stream_master_if.master   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;

  logic full;
  logic not_empty;
  logic rd_en;
  logic wr_en;

  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    not_empty = (count_q != '0);

    // A transfer needs a beat at the head; ready alone never reads.
    rd_en = not_empty && bus.ready_sys;

    // An X/Z valid_input takes the else branch, so it never writes.
    // A full FIFO still accepts when the head leaves on the same edge.
    if (bus.valid_input) begin
      wr_en = !full || rd_en;
    end else begin
      wr_en = 1'b0;
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_en) begin
      mem_d[wr_ptr_q] = bus.data_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Valid comes from registered state only, so it cannot follow ready_sys
  // combinationally; the head only moves on a read, keeping data_out stable.
  assign bus.valid    = (count_q != '0);
  assign bus.data_out = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_axi_stream_master.sv
// tb/tb_axi_stream_master.sv - directed self-checking bench for axi_stream_master

module tb_axi_stream_master;

  localparam int DW    = 512;
  localparam int DEPTH = 4;

  localparam logic [DW-1:0] A5   = 512'hA5A5A5A5A5A5A5A5;
  localparam logic [DW-1:0] V12  = 512'h1234567890ABCDEF;
  localparam logic [DW-1:0] BEEF = 512'hBEEF;

  logic clk;
  logic resetN;

  int n_checks;
  int n_fail;

  axi_stream_master_if #(.DATA_WIDTH(DW)) bus ();

  axi_stream_master #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vin, input logic rdy, input logic [DW-1:0] din);
    bus.valid_input = vin;
    bus.ready_sys   = rdy;
    bus.data_in     = din;
  endtask

  logic [DW-1:0] drain_exp [DEPTH];

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset held for 100 time units with inputs active: nothing gets in.
    resetN = 1'b0;
    drive(1'b1, 1'b1, A5);
    #100;
    check("rst_valid", 512'(bus.valid), 512'(0));
    check("rst_data",  bus.data_out,    512'(0));
    check("rst_count", 512'(dut.count_q), 512'(0));

    // Release between edges.
    step();
    resetN = 1'b1;

    // Streaming: count holds at 1, head tracks the input.
    drive(1'b1, 1'b1, A5);
    for (int i = 0; i < 10; i++) begin
      step();
      check("strm_valid", 512'(bus.valid), 512'(1));
      check("strm_data",  bus.data_out,    A5);
      check("strm_count", 512'(dut.count_q), 512'(1));
    end

    // Back-pressure: fills after 3 edges, later beats dropped, head stable.
    drive(1'b1, 1'b0, V12);
    for (int i = 1; i <= 10; i++) begin
      step();
      check("bp_valid", 512'(bus.valid), 512'(1));
      check("bp_data",  bus.data_out,    A5);
      check("bp_count", 512'(dut.count_q), 512'((i + 1 > DEPTH) ? DEPTH : i + 1));
    end

    // Drain: A5 then three 1234 beats, valid falls after the 4th edge.
    drive(1'b0, 1'b1, '0);
    drain_exp[0] = A5;
    drain_exp[1] = V12;
    drain_exp[2] = V12;
    drain_exp[3] = V12;
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_valid", 512'(bus.valid), 512'(1));
      check("drain_data",  bus.data_out,    drain_exp[i]);
      step();
    end
    check("drain_empty", 512'(bus.valid), 512'(0));
    check("drain_count", 512'(dut.count_q), 512'(0));

    // Idle.
    drive(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_valid", 512'(bus.valid), 512'(0));
      check("idle_count", 512'(dut.count_q), 512'(0));
    end

    // Fill with distinct beats 1..4, then one more that must be dropped.
    for (int i = 1; i <= DEPTH + 1; i++) begin
      drive(1'b1, 1'b0, 512'(i));
      step();
    end
    check("full_count", 512'(dut.count_q), 512'(DEPTH));
    check("full_head",  bus.data_out,      512'(1));

    // Full with simultaneous read and write: head advances, BEEF lands at tail.
    drive(1'b1, 1'b1, BEEF);
    step();
    check("rw_count", 512'(dut.count_q), 512'(DEPTH));
    check("rw_head",  bus.data_out,      512'(2));

    drive(1'b0, 1'b1, '0);
    drain_exp[0] = 512'(2);
    drain_exp[1] = 512'(3);
    drain_exp[2] = 512'(4);
    drain_exp[3] = BEEF;
    for (int i = 0; i < DEPTH; i++) begin
      check("rw_drain", bus.data_out, drain_exp[i]);
      step();
    end
    check("rw_empty", 512'(bus.valid), 512'(0));

    // Asynchronous reset mid-stream with three beats held.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 512'(16'hC0 + i));
      step();
    end
    check("mid_count", 512'(dut.count_q), 512'(3));
    #2;
    resetN = 1'b0;
    #1;
    check("async_valid", 512'(bus.valid), 512'(0));
    check("async_data",  bus.data_out,    512'(0));
    step();
    check("async_hold", 512'(bus.valid), 512'(0));
    resetN = 1'b1;

    // Resume: first beat after reset appears right after its edge.
    drive(1'b1, 1'b0, 512'(16'hD00D));
    step();
    check("resume_valid", 512'(bus.valid), 512'(1));
    check("resume_data",  bus.data_out,    512'(16'hD00D));
    drive(1'b0, 1'b1, '0);
    step();
    check("resume_empty", 512'(bus.valid), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
